// File: rtl/union_random_gen.sv
// XOR of several independent right-shifting Galois LFSRs; a fresh word every cycle.
// Each LFSR reloads its seed instead of ever sitting at zero.
module union_random_gen #(
    parameter int width_p  = 16,
    parameter int lfsr_num = 3,
    parameter logic [32*lfsr_num-1:0]      mask_p = {32'd17, 32'd39, 32'd13},
    parameter logic [width_p*lfsr_num-1:0] seed_p = {16'h8000, 16'h0100, 16'h0001}
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic [width_p-1:0] random_o
);

    if (width_p < 2) begin : g_bad_width
        $fatal(1, "union_random_gen: width_p must be >= 2");
    end
    if (lfsr_num < 1) begin : g_bad_num
        $fatal(1, "union_random_gen: lfsr_num must be >= 1");
    end

    logic [lfsr_num-1:0][width_p-1:0] states;

    for (genvar gi = 0; gi < lfsr_num; gi++) begin : g_lfsr
        localparam logic [31:0]        mask_w = mask_p[32*gi +: 32];
        localparam logic [width_p-1:0] mask_c = width_p'(mask_w);
        localparam logic [width_p-1:0] seed_c = seed_p[width_p*gi +: width_p];

        if (seed_c == '0) begin : g_bad_seed
            $fatal(1, "union_random_gen: every seed must be nonzero");
        end

        logic [width_p-1:0] state_reg;
        logic [width_p-1:0] state_next;
        logic [width_p-1:0] shifted;

        always_comb begin
            shifted    = (state_reg >> 1) ^ (state_reg[0] ? mask_c : '0);
            // A zero state would stick forever, so fall back to the seed.
            state_next = (shifted == '0) ? seed_c : shifted;
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                state_reg <= seed_c;
            end else begin
                state_reg <= state_next;
            end
        end

        assign states[gi] = state_reg;
    end

    always_comb begin
        random_o = '0;
        for (int k = 0; k < lfsr_num; k++) begin
            random_o = random_o ^ states[k];
        end
    end

endmodule

// File: tb/tb_union_random_gen.sv
// Randomized reset-pulse bench for union_random_gen against an arithmetic model of
// the LFSR step and XOR rules, across several parameter sets.
module tb_union_random_gen;

    logic        clk_i;
    logic        reset_i;
    logic [15:0] rand_a;
    logic [7:0]  rand_b;
    logic [3:0]  rand_c;
    logic [15:0] rand_d;

    int tests_run  = 0;
    int fail_count = 0;

    // Default parameters
    union_random_gen u_a (.clk_i(clk_i), .reset_i(reset_i), .random_o(rand_a));

    // 8-bit, masks truncated to 8 bits, one zero mask
    union_random_gen #(
        .width_p(8), .lfsr_num(3),
        .mask_p({32'd0, 32'd300, 32'h0000_01B8}),
        .seed_p({8'h80, 8'h5A, 8'h01})
    ) u_b (.clk_i(clk_i), .reset_i(reset_i), .random_o(rand_b));

    // Lock-up guard case
    union_random_gen #(
        .width_p(4), .lfsr_num(1), .mask_p(32'h3), .seed_p(4'h7)
    ) u_c (.clk_i(clk_i), .reset_i(reset_i), .random_o(rand_c));

    // Single raw LFSR
    union_random_gen #(
        .width_p(16), .lfsr_num(1), .mask_p(32'h0000_B400), .seed_p(16'hACE1)
    ) u_d (.clk_i(clk_i), .reset_i(reset_i), .random_o(rand_d));

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: plain integer arithmetic on the stated rules
    int a_mask[3] = '{13, 39, 17};
    int a_seed[3] = '{1, 'h100, 'h8000};
    int b_mask[3] = '{'h1B8, 300, 0};
    int b_seed[3] = '{1, 'h5A, 'h80};
    int c_mask = 3,      c_seed = 7;
    int d_mask = 'hB400, d_seed = 'hACE1;
    int a_s[3], b_s[3], c_s, d_s;

    function automatic int lfsr_next(int s, int mask, int seed, int w);
        int m = mask % (1 << w);
        int n = s / 2;
        if (s % 2 == 1) n = n ^ m;
        if (n == 0) return seed;
        return n;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            a_s[k] = a_seed[k];
            b_s[k] = b_seed[k];
        end
        c_s = c_seed;
        d_s = d_seed;
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            a_s[k] = lfsr_next(a_s[k], a_mask[k], a_seed[k], 16);
            b_s[k] = lfsr_next(b_s[k], b_mask[k], b_seed[k], 8);
        end
        c_s = lfsr_next(c_s, c_mask, c_seed, 4);
        d_s = lfsr_next(d_s, d_mask, d_seed, 16);
    endtask

    function automatic logic [15:0] exp_a();
        return 16'(a_s[0] ^ a_s[1] ^ a_s[2]);
    endfunction
    function automatic logic [7:0] exp_b();
        return 8'(b_s[0] ^ b_s[1] ^ b_s[2]);
    endfunction

    task automatic test_reset();
        reset_i = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            tests_run++;
            if (rand_a !== 16'h8101) begin
                fail_count++;
                $display("FAIL reset_a cycle %0d: got %h expected 8101", i, rand_a);
            end
            tests_run++;
            if (rand_b !== exp_b() || rand_c !== 4'h7 || rand_d !== 16'hACE1) begin
                fail_count++;
                $display("FAIL reset_others cycle %0d: got b=%h c=%h d=%h expected b=%h c=7 d=ace1",
                         i, rand_b, rand_c, rand_d, exp_b());
            end
        end
        $display("[TB] reset held 5 cycles: random_o=%h", rand_a);
    endtask

    task automatic test_first_steps();
        logic [15:0] want[2];
        want[0] = 16'h408D;
        want[1] = 16'h204B;
        @(negedge clk_i);
        reset_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_i);
            #1;
            model_step();
            tests_run++;
            if (rand_a !== want[i] || rand_a !== exp_a()) begin
                fail_count++;
                $display("FAIL first_step%0d: got %h expected %h", i + 1, rand_a, want[i]);
            end
            $display("[TB] step %0d: random_o=%h", i + 1, rand_a);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_i);
            #1;
            model_step();
        end
        tests_run++;
        if (rand_a !== exp_a()) begin
            fail_count++;
            $display("FAIL run100: got %h expected %h", rand_a, exp_a());
        end
        #2;
        reset_i = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if (rand_a !== 16'h8101) begin
            fail_count++;
            $display("FAIL async_reset: got %h expected 8101 before next edge", rand_a);
        end
        $display("[TB] async reset between edges: random_o=%h", rand_a);
        @(negedge clk_i);
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;
        model_step();
        tests_run++;
        if (rand_a !== 16'h408D) begin
            fail_count++;
            $display("FAIL restart_step1: got %h expected 408d", rand_a);
        end
        @(posedge clk_i);
        #1;
        model_step();
        tests_run++;
        if (rand_a !== 16'h204B) begin
            fail_count++;
            $display("FAIL restart_step2: got %h expected 204b", rand_a);
        end
        $display("[TB] restart after reset: random_o=%h", rand_a);
    endtask

    task automatic test_golden();
        int errs_before = fail_count;
        int hold = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_i);
            #1;
            if (!reset_i) model_step();
            tests_run++;
            if ($isunknown(rand_a) || rand_a !== exp_a()) begin
                fail_count++;
                $display("FAIL golden_a cycle %0d: got %h expected %h", i, rand_a, exp_a());
            end
            tests_run++;
            if ($isunknown(rand_b) || rand_b !== exp_b()) begin
                fail_count++;
                $display("FAIL golden_b cycle %0d: got %h expected %h", i, rand_b, exp_b());
            end
            tests_run++;
            if (rand_c !== 4'(c_s) || rand_c === 4'h0) begin
                fail_count++;
                $display("FAIL lockup_c cycle %0d: got %h expected %h", i, rand_c, 4'(c_s));
            end
            tests_run++;
            if (rand_d !== 16'(d_s)) begin
                fail_count++;
                $display("FAIL raw_d cycle %0d: got %h expected %h", i, rand_d, 16'(d_s));
            end
            // Random mid-cycle reset pulses
            if (hold > 0) begin
                hold--;
                if (hold == 0) begin
                    #2;
                    reset_i = 1'b0;
                end
            end else if ($urandom_range(0, 199) == 0) begin
                #2;
                reset_i = 1'b1;
                model_reset();
                hold = $urandom_range(1, 3);
                #1;
                tests_run++;
                if (rand_a !== 16'h8101 || rand_b !== exp_b()) begin
                    fail_count++;
                    $display("FAIL golden_async cycle %0d: got a=%h b=%h expected a=8101 b=%h",
                             i, rand_a, rand_b, exp_b());
                end
            end
        end
        $display("[TB] golden run 3000 cycles: %0d new failures", fail_count - errs_before);
    endtask

    initial begin
        reset_i = 1'b1;
        model_reset();
        test_reset();
        test_first_steps();
        test_async_reset();
        test_golden();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
